// File: rtl/param_counter_pkg.sv
// Shared types and constants for param_counter: count-mode encoding and direction values.
package param_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/param_counter_prescaler.sv
// Clock-enable prescaler: one tick every prescale+1 enabled cycles; clr restarts the period.
module param_counter_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  // The >= compare resolves a prescale lowered below the running count on the next enabled cycle.
  assign tick = en && (pre_cnt >= prescale);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/param_counter.sv
// Multi-mode counter (up/down/ping-pong/one-shot) with modulus, prescaler, load and tc pulse.
// Optional count snapshot register enabled by defining PARAM_COUNTER_CAPTURE_EN.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic [PRE_W-1:0] prescale,
  input  logic             capture,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done,
  output logic [WIDTH-1:0] cap_val
);

  mode_e            mode_sel;
  logic             tick;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             tc_nxt;
  logic             done_nxt;

  assign mode_sel = mode_e'(mode);

  param_counter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      count_nxt = (load_val > modulus) ? modulus : load_val;
      dir_nxt   = (mode_sel == MODE_DOWN) ? DIR_DOWN : DIR_UP;
      done_nxt  = 1'b0;
    end else if (tick) begin
      unique case (mode_sel)
        MODE_UP: begin
          dir_nxt = DIR_UP;
          if (count >= modulus) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          dir_nxt = DIR_DOWN;
          if (count == '0) begin
            count_nxt = modulus;
            tc_nxt    = 1'b1;
          end else if (count > modulus) begin
            count_nxt = modulus;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
        MODE_PINGPONG: begin
          if (dir == DIR_UP) begin
            if (count >= modulus) begin
              dir_nxt   = DIR_DOWN;
              count_nxt = (modulus == '0) ? '0 : modulus - WIDTH'(1);
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = count + WIDTH'(1);
            end
          end else begin
            if (count == '0) begin
              dir_nxt   = DIR_UP;
              count_nxt = (modulus == '0) ? '0 : WIDTH'(1);
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = count - WIDTH'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          dir_nxt = DIR_UP;
          // Once done, the count parks until the next load.
          if (!done) begin
            if (count >= modulus) begin
              count_nxt = modulus;
              done_nxt  = 1'b1;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = count + WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      dir   <= DIR_UP;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      dir   <= dir_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

`ifdef PARAM_COUNTER_CAPTURE_EN
  // Samples the pre-update count, so a coincident load still captures the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cap_val <= '0;
    else if (capture) cap_val <= count;
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_val        = '0;
`endif

endmodule

// File: tb/tb_param_counter.sv
// Directed self-checking bench for param_counter (WIDTH=4, PRE_W=4); honours PARAM_COUNTER_CAPTURE_EN.
module tb_param_counter;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;
`ifdef PARAM_COUNTER_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [PRE_W-1:0] prescale;
  logic             capture;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             done;
  logic [WIDTH-1:0] cap_val;

  int checks = 0;
  int errors = 0;

  param_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .modulus  (modulus),
    .prescale (prescale),
    .capture  (capture),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .done     (done),
    .cap_val  (cap_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pre_exp[7] = '{0, 0, 1, 1, 1, 2, 2};
    int pp_cnt[7]  = '{1, 2, 3, 2, 1, 0, 1};
    int pp_dir[7]  = '{1, 1, 1, 0, 0, 0, 1};
    int pp_tc[7]   = '{0, 0, 0, 1, 0, 0, 1};

    reset = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
    modulus = '0; prescale = '0; capture = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_dir", dir, 1);
    check("rst_tc", tc, 0);
    check("rst_done", done, 0);
    check("rst_cap", cap_val, 0);

    // Up wrap at modulus 5
    modulus = 4'd5; en = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("up_count", count, i % 6);
      check("up_tc", tc, (i == 6));
    end

    // Prescale by 3, then freeze with en low mid-period
    load = 1'b1; load_val = '0; prescale = 4'd2;
    step();
    load = 1'b0;
    check("pre_load_count", count, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("pre_count", count, pre_exp[i]);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("pre_frozen", count, 2);
    end
    en = 1'b1;
    step();
    check("pre_resume_wait", count, 2);
    step();
    check("pre_resume_tick", count, 3);

    // Ping-pong modulus 3 from reset
    reset = 1'b1; #1; reset = 1'b0;
    check("pp_reset_count", count, 0);
    mode = 2'b10; modulus = 4'd3; prescale = '0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("pp_count", count, pp_cnt[i]);
      check("pp_dir", dir, pp_dir[i]);
      check("pp_tc", tc, pp_tc[i]);
    end

    // Async reset at count 7, ping-pong, dir down
    en = 1'b0; mode = 2'b01; load_val = 4'd7; modulus = 4'd9; load = 1'b1;
    step();
    load = 1'b0; mode = 2'b10;
    check("ar_pre_count", count, 7);
    check("ar_pre_dir", dir, 0);
    step();
    check("ar_hold_count", count, 7);
    check("ar_hold_dir", dir, 0);
    #2; reset = 1'b1; #1;
    check("ar_count", count, 0);
    check("ar_dir", dir, 1);
    check("ar_tc", tc, 0);

    // One-shot to 4, hold, reload
    mode = 2'b11; modulus = 4'd4; prescale = '0; en = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("os_count", count, i);
      check("os_done", done, 0);
      check("os_tc", tc, 0);
    end
    step();
    check("os_end_count", count, 4);
    check("os_end_done", done, 1);
    check("os_end_tc", tc, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("os_hold_count", count, 4);
      check("os_hold_tc", tc, 0);
      check("os_hold_done", done, 1);
    end
    load_val = 4'd1; load = 1'b1;
    step();
    load = 1'b0;
    check("os_reload_count", count, 1);
    check("os_reload_done", done, 0);
    check("os_reload_tc", tc, 0);
    step();
    check("os_restart_count", count, 2);

    // Load beats tick and clamps to modulus; then down-count boundaries
    mode = 2'b00; modulus = 4'd9; load_val = 4'd12; load = 1'b1; en = 1'b1;
    step();
    load = 1'b0; mode = 2'b01;
    check("ld_clamp_count", count, 9);
    check("ld_clamp_tc", tc, 0);
    check("ld_clamp_dir", dir, 1);
    step();
    check("dn_count", count, 8);
    check("dn_dir", dir, 0);
    check("dn_tc", tc, 0);
    modulus = 4'd5;
    step();
    check("dn_lower_mod_count", count, 5);
    check("dn_lower_mod_tc", tc, 0);
    load_val = '0; load = 1'b1;
    step();
    load = 1'b0;
    check("dn_load0_count", count, 0);
    check("dn_load0_dir", dir, 0);
    step();
    check("dn_wrap_count", count, 5);
    check("dn_wrap_tc", tc, 1);

    // Modulus 0 in up mode: count pinned at 0, tc every tick
    mode = 2'b00; modulus = '0;
    step();
    check("m0_count_a", count, 0);
    check("m0_tc_a", tc, 1);
    step();
    check("m0_count_b", count, 0);
    check("m0_tc_b", tc, 1);
    check("m0_dir", dir, 1);

    // Capture
    en = 1'b0; modulus = 4'd9; load_val = 4'd6; load = 1'b1;
    step();
    load = 1'b0;
    check("cap_setup_count", count, 6);
    capture = 1'b1;
    step();
    capture = 1'b0;
    check("cap_val_6", cap_val, CAP_EN ? 6 : 0);
    en = 1'b1;
    step();
    check("cap_next_count", count, 7);
    check("cap_held", cap_val, CAP_EN ? 6 : 0);
    en = 1'b0; load_val = 4'd2; load = 1'b1; capture = 1'b1;
    step();
    load = 1'b0; capture = 1'b0;
    check("cap_ld_count", count, 2);
    check("cap_ld_old", cap_val, CAP_EN ? 7 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
